// File: rtl/modbus_rx_frame.sv
// Modbus RTU read-holding-registers response receiver with CRC-16 check,
// write-echo discard, exception reporting, gap resync and saturating statistics.
module modbus_rx_frame #(
  parameter int          NUM_REGS   = 10,
  parameter logic [7:0]  SLAVE_ADDR = 8'h02,
  parameter logic [7:0]  FUNC_READ  = 8'h03,
  parameter logic [7:0]  FUNC_WRITE = 8'h06,
  parameter int          GAP_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [16*NUM_REGS-1:0]  regs,
  output logic                    frame_ok,
  output logic                    crc_err,
  output logic                    exc_valid,
  output logic [7:0]              exc_code,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             err_cnt,
  output logic                    busy
);

  localparam logic [7:0] BYTE_CNT  = 8'(2 * NUM_REGS);
  localparam logic [7:0] BYTE_LAST = 8'(2 * NUM_REGS - 1);
  localparam int         GW        = $clog2(GAP_CYCLES + 1);
  localparam int         SW        = $clog2(16 * NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_FUNC, S_BCNT, S_DATA, S_EXC, S_CRC_LO, S_CRC_HI, S_ECHO, S_SKIP
  } state_t;

  state_t                  state, state_n;
  logic [15:0]             crc, crc_upd;
  logic [GW-1:0]           gap;
  logic [7:0]              idx;
  logic                    is_exc;
  logic [7:0]              exc_pend;
  logic [16*NUM_REGS-1:0]  shadow;
  logic [SW-1:0]           sh_pos;
  logic                    expire, pass_rd, pass_exc, fail, err_inc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  assign crc_upd = crc_byte(crc, rx_data);
  assign expire  = (state != S_IDLE) && !rx_valid && (gap == GW'(GAP_CYCLES - 1));
  assign busy    = (state != S_IDLE);
  // Even byte index carries the high byte of its register.
  assign sh_pos  = SW'({idx[7:1], 4'b0000}) + (idx[0] ? SW'(0) : SW'(8));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pass_rd  = 1'b0;
    pass_exc = 1'b0;
    fail     = 1'b0;
    err_inc  = 1'b0;
    if (expire) begin
      state_n = S_IDLE;
      err_inc = state inside {S_BCNT, S_DATA, S_EXC, S_CRC_LO, S_CRC_HI};
    end else if (rx_valid) begin
      case (state)
        S_IDLE:   state_n = (rx_data == SLAVE_ADDR) ? S_FUNC : S_SKIP;
        S_FUNC: begin
          if (rx_data == FUNC_READ)                  state_n = S_BCNT;
          else if (rx_data == FUNC_WRITE)            state_n = S_ECHO;
          else if (rx_data == (FUNC_READ | 8'h80))   state_n = S_EXC;
          else                                       state_n = S_SKIP;
        end
        S_BCNT: begin
          if (rx_data == BYTE_CNT) state_n = S_DATA;
          else begin
            state_n = S_SKIP;
            err_inc = 1'b1;
          end
        end
        S_DATA:   if (idx == BYTE_LAST) state_n = S_CRC_LO;
        S_EXC:    state_n = S_CRC_LO;
        S_CRC_LO: state_n = S_CRC_HI;
        S_CRC_HI: begin
          state_n = S_IDLE;
          if (crc_upd == 16'h0000) begin
            pass_exc = is_exc;
            pass_rd  = !is_exc;
          end else begin
            fail    = 1'b1;
            err_inc = 1'b1;
          end
        end
        S_ECHO:   if (idx == 8'd5) state_n = S_IDLE;
        S_SKIP:   state_n = S_SKIP;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs      <= '0;
      shadow    <= '0;
      frame_ok  <= 1'b0;
      crc_err   <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= 8'h00;
      exc_pend  <= 8'h00;
      frame_cnt <= 16'h0000;
      err_cnt   <= 16'h0000;
      crc       <= 16'hFFFF;
      gap       <= '0;
      idx       <= 8'h00;
      is_exc    <= 1'b0;
    end else begin
      frame_ok  <= pass_rd;
      crc_err   <= fail;
      exc_valid <= pass_exc;
      gap       <= (rx_valid || state == S_IDLE || expire) ? '0 : gap + GW'(1);
      if (state_n == S_IDLE) crc <= 16'hFFFF;
      else if (rx_valid)     crc <= crc_upd;
      if (rx_valid) begin
        idx <= (state == S_FUNC || state == S_BCNT) ? 8'h00 : idx + 8'h01;
        if (state == S_FUNC) is_exc   <= (state_n == S_EXC);
        if (state == S_EXC)  exc_pend <= rx_data;
        if (state == S_DATA) shadow[sh_pos +: 8] <= rx_data;
      end
      if (pass_rd) regs <= shadow;
      if (pass_exc) exc_code <= exc_pend;
      if (pass_rd && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'h0001;
      if (err_inc && err_cnt != 16'hFFFF)   err_cnt   <= err_cnt + 16'h0001;
    end
  end

endmodule

// File: doc/modbus_rx_frame.md
# modbus_rx_frame

Parametrised Modbus RTU response receiver that replaces the fixed 25-byte, 10-register parser behind the UART byte receiver. It parses read-holding-registers responses (address, function, byte count, data, CRC) addressed to this node and checks the CRC-16. It publishes NUM_REGS 16-bit registers atomically, and only for valid frames. It also consumes single-register write echoes, reports exception responses, resynchronises on inter-frame gaps and keeps frame/error statistics.

## Interface
- NUM_REGS, 10, registers per read response (1..125); expected byte count = 2*NUM_REGS
- SLAVE_ADDR, 8'h02, node address accepted in byte 0
- FUNC_READ, 8'h03, read-holding-registers function code
- FUNC_WRITE, 8'h06, write-single-register function code (8-byte echo, discarded)
- GAP_CYCLES, 2000, idle clk cycles that terminate or abort a frame
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe per received byte
- regs  out  16*NUM_REGS  register k on [16k+15:16k], high byte first on the wire
- frame_ok  out  1  one-cycle pulse when regs updated
- crc_err  out  1  one-cycle pulse on CRC failure of a parsed frame
- exc_valid  out  1  one-cycle pulse on a valid exception response
- exc_code  out  8  last exception code, held
- frame_cnt  out  16  good read frames, saturating
- err_cnt  out  16  CRC, byte-count and timeout errors, saturating
- busy  out  1  high whenever state != IDLE

## Operation
- Reset: all outputs 0, state IDLE, CRC = 16'hFFFF, gap timer 0.
- CRC: Modbus CRC-16, reflected polynomial 16'hA001, init 16'hFFFF, updated one byte per rx_valid over every byte of the frame including both CRC bytes. Frame passes when the final value = 16'h0000. CRC reinitialised on every entry to IDLE.
- States:
  - IDLE: on a byte, if it equals SLAVE_ADDR -> FUNC, else -> SKIP.
  - FUNC: FUNC_READ -> BCNT; FUNC_WRITE -> ECHO (6 more bytes); FUNC_READ|8'h80 -> EXC; other -> SKIP.
  - BCNT: byte = 2*NUM_REGS -> DATA with byte index 0; else err_cnt+1 -> SKIP.
  - DATA: byte written to shadow buffer at index; after byte 2*NUM_REGS-1 -> CRC_LO.
  - EXC: byte latched as pending code -> CRC_LO.
  - CRC_LO -> CRC_HI. In CRC_HI, evaluate the CRC on the byte:
    - pass for a read frame: copy shadow to regs, pulse frame_ok, frame_cnt+1.
    - pass for an exception frame: load exc_code, pulse exc_valid.
    - fail: pulse crc_err, err_cnt+1, regs unchanged.
    - all cases -> IDLE.
  - ECHO: counts 6 bytes, no checks, no outputs -> IDLE.
  - SKIP: discards bytes until gap expiry -> IDLE, no error counted.
- Gap timer: cleared on every rx_valid and in IDLE; increments otherwise. Reaching GAP_CYCLES forces IDLE. If expiry happens in BCNT, DATA, EXC, CRC_LO or CRC_HI, err_cnt+1 and regs stay unchanged. Expiry in FUNC, ECHO or SKIP counts no error.
- regs never shows a partial frame; shadow contents of aborted frames are discarded.
- Counters saturate at 16'hFFFF.
- rst_n assertion mid-frame: immediate return to reset values, including regs.

## Timing
- One byte is accepted per rx_valid; back-to-back rx_valid on consecutive cycles is supported.
- Last CRC byte strobed at cycle t -> regs, frame_ok/crc_err/exc_valid and counters updated at edge t+1. Pulses last exactly one cycle.
- Gap expiry occurs GAP_CYCLES cycles after the last rx_valid. rx_valid in the expiry cycle wins: the byte is processed and the timer clears.
- busy rises the cycle after the first byte and falls in the cycle the state returns to IDLE.

## Test plan
- NUM_REGS=10, frame 02 03 14 then data 00 01 .. 00 0A, then correct CRC -> frame_ok pulse at t+1; regs[15:0]=16'h0001, regs[159:144]=16'h000A; frame_cnt=1.
- Same frame with last data byte flipped -> crc_err pulse, err_cnt=1, regs keep prior values.
- Echo 02 06 00 10 12 34 CRC CRC, then a valid read frame back-to-back -> echo ignored with no pulses; read frame accepted.
- Address 05 frame followed by a GAP_CYCLES idle period, then a valid frame -> first ignored, no error; second gives frame_ok.
- Read frame stopped after 7 data bytes, idle GAP_CYCLES -> err_cnt+1, busy falls, no frame_ok; next valid frame accepted.
- Exception 02 83 02 CRC CRC -> exc_valid pulse, exc_code=8'h02; rst_n pulsed mid-frame -> all outputs 0.
